// File: rtl/vga_scan_reader.sv
// vga_scan_reader: display-side reader for the video RAM's second read port.
// Generates VGA timing (640x480@60 by default) from the system clock. It walks
// the RAM as a 2^ROW_BITS x 2^COL_BITS grid of colour cells, each CELL_W x
// CELL_H pixels. Each cell's colour is registered onto RGB444 pins, and the
// syncs are registered in the same stage so they stay aligned with the colour.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   dispAddr     RAM display read address = {row, col}
//   dispColor    RAM word at dispAddr (combinational, same cycle); bits [11:0] used
//   vga_r/g/b    4-bit colour, zero during blanking
//   hsync/vsync  active-low syncs
//   frame_start  one-clk pulse when the counters wrap to pixel (0,0)
module vga_scan_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int COL_BITS   = 5,
  parameter int ROW_BITS   = 5,
  parameter int CELL_W     = 20,
  parameter int CELL_H     = 15,
  parameter int CLK_DIV    = 4,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] dispAddr,
  input  logic [DATA_WIDTH-1:0] dispColor,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW  = $clog2(H_TOTAL);
  localparam int VW  = $clog2(V_TOTAL);
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CXW = (CELL_W  > 1) ? $clog2(CELL_W)  : 1;
  localparam int CYW = (CELL_H  > 1) ? $clog2(CELL_H)  : 1;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]  H_VIS    = HW'(H_VISIBLE);
  localparam logic [VW-1:0]  V_VIS    = VW'(V_VISIBLE);
  localparam logic [HW-1:0]  HS_BEG   = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0]  HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VW-1:0]  VS_BEG   = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0]  VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [CXW-1:0] CX_LAST  = CXW'(CELL_W - 1);
  localparam logic [CYW-1:0] CY_LAST  = CYW'(CELL_H - 1);

  logic [DW-1:0]       div_q, div_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;
  logic [VW-1:0]       vcnt_q, vcnt_d;
  logic [CXW-1:0]      cell_x_q, cell_x_d;
  logic [CYW-1:0]      cell_y_q, cell_y_d;
  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [11:0]         rgb_q, rgb_d;
  logic                hs_q, hs_d, vs_q, vs_d, fs_q;
  logic                pix_en, h_end, v_end, h_vis, v_vis;

  // Only the 12-bit colour field of the RAM word is displayed.
  logic color_unused;
  assign color_unused = ^dispColor[DATA_WIDTH-1:12];

  always_comb begin
    pix_en = (div_q == DIV_LAST);
    h_end  = (hcnt_q == H_LAST);
    v_end  = (vcnt_q == V_LAST);
    h_vis  = (hcnt_q < H_VIS);
    v_vis  = (vcnt_q < V_VIS);

    div_d  = pix_en ? '0 : div_q + 1'b1;
    hcnt_d = h_end ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_end) vcnt_d = v_end ? '0 : vcnt_q + 1'b1;

    // Horizontal cell walk; col wraps to 0 on its own at the last visible
    // pixel, the forced clear at line end just guards the invariant.
    cell_x_d = cell_x_q;
    col_d    = col_q;
    if (h_end) begin
      cell_x_d = '0;
      col_d    = '0;
    end else if (h_vis) begin
      if (cell_x_q == CX_LAST) begin
        cell_x_d = '0;
        col_d    = col_q + 1'b1;
      end else begin
        cell_x_d = cell_x_q + 1'b1;
      end
    end

    // Vertical cell walk advances once per line, at line end.
    cell_y_d = cell_y_q;
    row_d    = row_q;
    if (h_end) begin
      if (v_end) begin
        cell_y_d = '0;
        row_d    = '0;
      end else if (v_vis) begin
        if (cell_y_q == CY_LAST) begin
          cell_y_d = '0;
          row_d    = row_q + 1'b1;
        end else begin
          cell_y_d = cell_y_q + 1'b1;
        end
      end
    end

    // Output stage sees the same counter state that produced dispAddr, so
    // colour and syncs come out together one pixel tick later.
    rgb_d = (h_vis && v_vis) ? dispColor[11:0] : 12'h000;
    hs_d  = ~((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
    vs_d  = ~((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      cell_x_q <= '0;
      cell_y_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      div_q <= div_d;
      // Pulse during the clk right after the tick that wraps to (0,0).
      fs_q  <= pix_en && h_end && v_end;
      if (pix_en) begin
        hcnt_q   <= hcnt_d;
        vcnt_q   <= vcnt_d;
        cell_x_q <= cell_x_d;
        cell_y_q <= cell_y_d;
        col_q    <= col_d;
        row_q    <= row_d;
        rgb_q    <= rgb_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
      end
    end
  end

  assign dispAddr    = {row_q, col_q};
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Bench for vga_scan_reader on a scaled-down geometry: 8x8 cells of 5x3
// pixels, 40x24 visible, H_TOTAL=56, V_TOTAL=30, CLK_DIV=4, so a frame is
// 6720 clks. Expectations carry the absolute clk count at which they apply;
// the monitor compares them at the negedge of that clk.
module tb_vga_scan_reader;
  localparam int AW    = 6;
  localparam int HT    = 56;
  localparam int VT    = 30;
  localparam int FRAME = HT * VT * 4;

  localparam int K_ADDR = 0, K_RGB = 1, K_HS = 2, K_VS = 3, K_FS = 4, K_FCNT = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] dispAddr;
  logic [31:0]   dispColor;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          hsync, vsync, frame_start;

  vga_scan_reader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .COL_BITS(3), .ROW_BITS(3),
    .CELL_W(5), .CELL_H(3), .CLK_DIV(4),
    .H_VISIBLE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VISIBLE(24), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .clk(clk), .rst(rst), .dispAddr(dispAddr), .dispColor(dispColor),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int tclk = 0;   // posedges so far
  int rel  = 0;   // tclk at the last reset release
  always @(posedge clk) tclk <= tclk + 1;

  // Model RAM: the real colour (with junk upper bits) is only present on the
  // clk before a pixel-tick edge; a different word is offered otherwise.
  logic [1:0] ph;
  always_comb begin
    ph        = 2'(tclk - rel);
    dispColor = (ph == 2'd3) ? 32'hFFFF_0A5C : 32'h0000_05A3;
  end

  typedef struct {
    int          at;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   fs_cnt = 0;

  task automatic push(input int at, input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.at = at; e.kind = kind; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  // clk index (relative to release) at which counters sit at pixel (x,y)
  function automatic int A(input int x, input int y);
    return 4 * (y * HT + x);
  endfunction
  // clk index at which outputs show pixel (x,y)
  function automatic int O(input int x, input int y);
    return A(x, y) + 4;
  endfunction

  task automatic push_reset_state(input int at, input string tag);
    push(at, K_ADDR, 32'h0,   {tag, "_addr"});
    push(at, K_RGB,  32'h000, {tag, "_rgb"});
    push(at, K_HS,   32'h1,   {tag, "_hsync"});
    push(at, K_VS,   32'h1,   {tag, "_vsync"});
    push(at, K_FS,   32'h0,   {tag, "_fs"});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [31:0] act;
    if (frame_start === 1'b1) fs_cnt++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == tclk) begin
        case (sb[i].kind)
          K_ADDR:  act = 32'(dispAddr);
          K_RGB:   act = {20'h0, vga_r, vga_g, vga_b};
          K_HS:    act = {31'h0, hsync};
          K_VS:    act = {31'h0, vsync};
          K_FS:    act = {31'h0, frame_start};
          default: act = 32'(fs_cnt);
        endcase
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s at clk %0d: got %0h expected %0h", sb[i].name, tclk, act, sb[i].val);
        end
        sb.delete(i);
      end else if (sb[i].at < tclk) begin
        checks++;
        errors++;
        $display("FAIL %s: sample point clk %0d missed", sb[i].name, sb[i].at);
        sb.delete(i);
      end
    end
  end

  initial begin
    int f3, fin;
    // Power-on reset for 10 clks
    repeat (9) @(negedge clk);
    push_reset_state(tclk + 1, "por");
    @(negedge clk);
    rst = 1'b0;
    rel = tclk;

    // No pulse on release; first tick lands 4 clks after release
    push(rel + 1,          K_FS,   32'h0,   "fs_release");
    push(rel + 3,          K_ADDR, 32'd0,   "addr_0_0");
    push(rel + 3,          K_RGB,  32'h000, "rgb_pre_tick");
    push(rel + O(0, 0),    K_RGB,  32'hA5C, "rgb_0_0");
    push(rel + A(4, 0)+3,  K_ADDR, 32'd0,   "addr_4_0");
    push(rel + A(5, 0),    K_ADDR, 32'd1,   "addr_5_0");
    push(rel + A(39, 0),   K_ADDR, 32'd7,   "addr_39_0");
    push(rel + A(40, 0),   K_ADDR, 32'd0,   "addr_col_wrap");
    push(rel + O(39, 0),   K_RGB,  32'hA5C, "rgb_39_0");
    push(rel + O(40, 0),   K_RGB,  32'h000, "rgb_hblank");
    push(rel + O(55, 0),   K_RGB,  32'h000, "rgb_line_end");
    push(rel + O(43, 1),   K_HS,   32'h1,   "hs_before");
    push(rel + O(44, 1),   K_HS,   32'h0,   "hs_first_low");
    push(rel + O(51, 1)+3, K_HS,   32'h0,   "hs_last_low");
    push(rel + O(52, 1),   K_HS,   32'h1,   "hs_after");
    push(rel + A(0, 2),    K_ADDR, 32'd0,   "addr_0_2");
    push(rel + A(0, 3),    K_ADDR, 32'd8,   "addr_0_3");
    push(rel + A(50, 7),   K_ADDR, 32'd16,  "addr_blank_50_7");
    push(rel + A(55, 7)+3, K_ADDR, 32'd16,  "addr_blank_55_7");
    push(rel + O(0, 23),   K_RGB,  32'hA5C, "rgb_0_23");
    push(rel + A(39, 23),  K_ADDR, 32'd63,  "addr_39_23");
    push(rel + O(39, 23),  K_RGB,  32'hA5C, "rgb_39_23");
    push(rel + A(0, 24),   K_ADDR, 32'd0,   "addr_vblank");
    push(rel + O(0, 24),   K_RGB,  32'h000, "rgb_vblank");
    push(rel + O(55, 25),  K_VS,   32'h1,   "vs_before");
    push(rel + O(0, 26),   K_VS,   32'h0,   "vs_first_low");
    push(rel + O(55, 27),  K_VS,   32'h0,   "vs_last_low");
    push(rel + O(0, 28),   K_VS,   32'h1,   "vs_after");
    push(rel + FRAME - 1,  K_FS,   32'h0,   "fs1_early");
    push(rel + FRAME,      K_FS,   32'h1,   "fs1");
    push(rel + FRAME + 1,  K_FS,   32'h0,   "fs1_width");
    push(rel + FRAME + A(5, 0), K_ADDR, 32'd1, "addr_frame2_5_0");
    push(rel + 2*FRAME,    K_FS,   32'h1,   "fs2");
    push(rel + 2*FRAME + 1, K_FS,  32'h0,   "fs2_width");

    // Mid-frame reset at pixel (30,20) of the third frame
    f3 = rel + 2*FRAME;
    while (tclk < rel + 2*FRAME + 8) @(negedge clk);
    push(f3 + A(30, 20), K_ADDR, 32'd54,  "addr_30_20");
    push(f3 + A(30, 20), K_RGB,  32'hA5C, "rgb_29_20");
    while (tclk < f3 + A(30, 20) + 1) @(negedge clk);
    push_reset_state(tclk + 1, "midrst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rel = tclk;
    push(rel + 3,         K_ADDR, 32'd0,   "rst2_addr_0_0");
    push(rel + O(0, 0),   K_RGB,  32'hA5C, "rst2_rgb_0_0");
    push(rel + A(5, 0),   K_ADDR, 32'd1,   "rst2_addr_5_0");
    push(rel + FRAME - 1, K_FS,   32'h0,   "fs3_early");
    push(rel + FRAME,     K_FS,   32'h1,   "fs3");
    push(rel + FRAME + 1, K_FS,   32'h0,   "fs3_width");

    while (tclk < rel + FRAME + 10) @(negedge clk);
    fin = tclk + 2;
    push(fin, K_FCNT, 32'd3, "fs_count");
    while (tclk < fin + 2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
